// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// Writeback stage between the memory stage and the register-file write port.
// Each accepted instruction is turned into a {we, addr, data} result and
// placed in a small circular queue. The queue absorbs downstream stalls, so
// no result is dropped while the write port is blocked.
//
// Result formation:
//   JAL / JALR : pc + 4
//   LOAD       : lane selected from rd_data by the low address bits,
//                then sign- or zero-extended
//   other      : ALU result a
//   Stores, branches, writes to x0 and illegal load widths do not write.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   ir               instruction word
//   rd_data          memory read data (aligned word / dword)
//   a                ALU result, or effective address for loads
//   pc               instruction PC
//   v_in / r_out     upstream handshake; r_out depends on occupancy only
//   stall            downstream stall; blocks pop and register write
//   v_out            head entry present
//   wr_en/addr/data  register-file write port, driven from the head entry
//   fwd_*            forwarding tap on the youngest queued entry
//   instret          number of popped (retired) entries, wraps
// -----------------------------------------------------------------------------
module writeback_queue #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ir,
  input  logic [XLEN-1:0]   rd_data,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   pc,
  input  logic              v_in,
  output logic              r_out,
  input  logic              stall,
  output logic              v_out,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [XLEN-1:0]   wr_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [XLEN-1:0]   fwd_data,
  output logic [CNT_W-1:0]  instret
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_QW = $clog2(DEPTH + 1);
  localparam logic [CNT_QW-1:0] FULL_COUNT = CNT_QW'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Result formation
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [2:0]      lane_off;   // byte offset inside the aligned word/dword
  logic [5:0]      sh_byte;
  logic [5:0]      sh_half;
  logic [5:0]      sh_word;
  logic [XLEN-1:0] rd_byte_sh;
  logic [XLEN-1:0] rd_half_sh;
  logic [XLEN-1:0] rd_word_sh;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_word;
  logic            load_legal;
  logic [XLEN-1:0] load_data;
  entry_t          new_entry;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];

  // Only XLEN=64 uses a[2]; forcing it to zero for XLEN=32 keeps the word
  // lane at 0 and the byte/half offsets inside 32 bits.
  assign lane_off = (XLEN == 64) ? a[2:0] : {1'b0, a[1:0]};
  assign sh_byte  = {lane_off, 3'b000};
  assign sh_half  = {lane_off[2:1], 4'b0000};
  assign sh_word  = {lane_off[2], 5'b00000};

  assign rd_byte_sh = rd_data >> sh_byte;
  assign rd_half_sh = rd_data >> sh_half;
  assign rd_word_sh = rd_data >> sh_word;
  assign ld_byte    = rd_byte_sh[7:0];
  assign ld_half    = rd_half_sh[15:0];
  assign ld_word    = rd_word_sh[31:0];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statements can leave it unassigned and infer a latch.
  always_comb begin
    load_legal = 1'b1;
    load_data  = rd_data;
    unique case (funct3)
      3'd0: load_data = XLEN'($signed(ld_byte));
      3'd1: load_data = XLEN'($signed(ld_half));
      3'd2: load_data = XLEN'($signed(ld_word));
      3'd4: load_data = XLEN'(ld_byte);
      3'd5: load_data = XLEN'(ld_half);
      3'd6: begin
        load_data  = XLEN'(ld_word);
        load_legal = (XLEN == 64);
      end
      3'd3: begin
        load_data  = rd_data;
        load_legal = (XLEN == 64);
      end
      default: load_legal = 1'b0;
    endcase
  end

  always_comb begin
    new_entry.addr = REG_AW'(ir[11:7]);
    new_entry.data = a;
    new_entry.we   = 1'b1;
    unique case (opcode)
      OP_JAL, OP_JALR: new_entry.data = pc + XLEN'(4);
      OP_LOAD: begin
        new_entry.data = load_data;
        new_entry.we   = load_legal;
      end
      OP_STORE, OP_BRANCH: new_entry.we = 1'b0;
      default: ;
    endcase
    if (new_entry.addr == '0) new_entry.we = 1'b0;
  end

  // Upper instruction bits are immediates / rs fields, not needed here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[31:15];

  // ---------------------------------------------------------------------------
  // Queue
  // ---------------------------------------------------------------------------
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [CNT_QW-1:0]  count;
  logic               push;
  logic               pop;
  entry_t             head_entry;
  entry_t             tail_entry;

  // Outputs are gated by rst as well as by count: reset is synchronous, so
  // during the first reset cycle count still holds its pre-reset value.
  assign r_out = ~rst & (count < FULL_COUNT);
  assign v_out = ~rst & (count != '0);
  assign push  = v_in & r_out;
  assign pop   = v_out & ~stall;

  assign tail_ptr   = wr_ptr - 1'b1;
  assign head_entry = mem[rd_ptr];
  assign tail_entry = mem[tail_ptr];

  assign wr_en     = v_out & head_entry.we & ~stall;
  assign wr_addr   = head_entry.addr;
  assign wr_data   = head_entry.data;
  assign fwd_valid = v_out & tail_entry.we;
  assign fwd_addr  = tail_entry.addr;
  assign fwd_data  = tail_entry.data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      instret <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        instret <= instret + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; count gates every consumer, so
  // stale contents are never observed and the array can map to plain flops
  // or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
//
// Scoreboard bench for writeback_queue (XLEN=32, DEPTH=2). Stimulus pushes
// expected results, formed by a byte-level reference model, into a queue;
// a negedge monitor tracks occupancy and retirement and compares every
// handshake, write port, forwarding tap and instret value against it.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       ir;
  logic [XLEN-1:0]   rd_data;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   pc;
  logic              v_in;
  logic              r_out;
  logic              stall;
  logic              v_out;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [XLEN-1:0]   fwd_data;
  logic [CNT_W-1:0]  instret;

  writeback_queue #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ir(ir), .rd_data(rd_data), .a(a), .pc(pc),
    .v_in(v_in), .r_out(r_out), .stall(stall), .v_out(v_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        we;
    bit [4:0]  addr;
    bit [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_instret = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          stall_force = 0;
  bit          rand_en = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: decode straight from the ISA rules using a byte array.
  function automatic exp_t model(bit [31:0] i, bit [31:0] rd, bit [31:0] ad, bit [31:0] p);
    exp_t      e;
    bit [7:0]  bytes[4];
    bit [15:0] half;
    int        bi;
    int        hi;
    for (int k = 0; k < 4; k++) bytes[k] = rd[8*k +: 8];
    bi     = int'(ad[1:0]);
    hi     = int'(ad[1]);
    half   = {bytes[2*hi+1], bytes[2*hi]};
    e.addr = i[11:7];
    e.we   = 1'b1;
    e.data = ad;
    case (i[6:0])
      7'b1101111, 7'b1100111: e.data = p + 32'd4;
      7'b0100011, 7'b1100011: e.we = 1'b0;
      7'b0000011: begin
        case (i[14:12])
          3'd0: e.data = {{24{bytes[bi][7]}}, bytes[bi]};
          3'd1: e.data = {{16{half[15]}}, half};
          3'd2: e.data = rd;
          3'd4: e.data = {24'd0, bytes[bi]};
          3'd5: e.data = {16'd0, half};
          default: e.we = 1'b0;
        endcase
      end
      default: ;
    endcase
    if (e.addr == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  exp_t hd;
  exp_t tl;
  bit   r_exp;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_r_out", r_out, 0);
      check("rst_v_out", v_out, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_fwd_valid", fwd_valid, 0);
      sb.delete();
      m_instret = 0;
    end else begin
      r_exp = (sb.size() < DEPTH);
      check("r_out", r_out, r_exp);
      check("v_out", v_out, sb.size() != 0);
      check("instret", instret, m_instret);
      if (sb.size() != 0) begin
        hd = sb[0];
        tl = sb[$];
        check("wr_en", wr_en, hd.we & ~stall);
        if (hd.we) begin
          check("wr_addr", wr_addr, hd.addr);
          check("wr_data", wr_data, hd.data);
        end
        check("fwd_valid", fwd_valid, tl.we);
        if (tl.we) begin
          check("fwd_addr", fwd_addr, tl.addr);
          check("fwd_data", fwd_data, tl.data);
        end
        if (!stall) begin
          void'(sb.pop_front());
          m_instret++;
        end
      end else begin
        check("idle_wr_en", wr_en, 0);
        check("idle_fwd_valid", fwd_valid, 0);
      end
      if (v_in && r_exp) sb.push_back(model(ir, rd_data, a, pc));
    end
  end

  // Stall generator: forced value or random back-pressure.
  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      stall = stall_force | (rand_en && $urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Called at posedge+1; holds v_in until the DUT accepts (bounded).
  task automatic send(input bit [31:0] i, input bit [31:0] rd, input bit [31:0] ad,
                      input bit [31:0] p);
    bit acc;
    acc = 0;
    ir = i; rd_data = rd; a = ad; pc = p; v_in = 1'b1;
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge clk);
      acc = r_out;
      @(posedge clk);
      #1;
    end
    check("send_accepted", acc, 1);
    v_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit [31:0] enc_i(bit [11:0] imm, bit [4:0] rs1, bit [2:0] f3,
                                      bit [4:0] rd, bit [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  bit [6:0] ops[8] = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011,
                       7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  initial begin
    bit [31:0] ri;
    rst = 1'b1; v_in = 1'b0; ir = '0; rd_data = '0; a = '0; pc = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("release_r_out", r_out, 1);
    check("release_v_out", v_out, 0);
    check("release_instret", instret, 0);
    @(posedge clk);
    #1;

    // Directed result formation.
    send(enc_i(12'h000, 5'd0, 3'b000, 5'd5, 7'b0010011), 32'h0, 32'h1234, 32'h0);   // ADDI x5
    send(enc_i(12'h000, 5'd1, 3'b000, 5'd3, 7'b0000011), 32'h80FF7F01, 32'h2, 32'h0); // LB
    send(enc_i(12'h000, 5'd1, 3'b101, 5'd3, 7'b0000011), 32'h80FF7F01, 32'h2, 32'h0); // LHU
    send(enc_i(12'h000, 5'd1, 3'b001, 5'd4, 7'b0000011), 32'h80FF7F01, 32'h3, 32'h0); // LH
    send(enc_i(12'h000, 5'd1, 3'b100, 5'd4, 7'b0000011), 32'h80FF7F01, 32'h1, 32'h0); // LBU
    send(enc_i(12'h000, 5'd1, 3'b010, 5'd4, 7'b0000011), 32'h80FF7F01, 32'h0, 32'h0); // LW
    send({20'h0, 5'd1, 7'b1101111}, 32'h0, 32'h0, 32'h100);                           // JAL
    send(enc_i(12'h000, 5'd2, 3'b000, 5'd9, 7'b1100111), 32'h0, 32'h0, 32'hFFFFFFFC); // JALR wrap
    send(enc_i(12'h000, 5'd1, 3'b010, 5'd4, 7'b0100011), 32'h0, 32'h55, 32'h0);       // store
    send(enc_i(12'h000, 5'd1, 3'b000, 5'd8, 7'b1100011), 32'h0, 32'h55, 32'h0);       // branch
    send(enc_i(12'h000, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'h0, 32'h77, 32'h0);       // rd=x0
    send(enc_i(12'h000, 5'd1, 3'b011, 5'd4, 7'b0000011), 32'h1, 32'h0, 32'h0);        // LD illegal
    send(enc_i(12'h000, 5'd1, 3'b110, 5'd4, 7'b0000011), 32'h1, 32'h0, 32'h0);        // LWU illegal
    send(enc_i(12'h000, 5'd1, 3'b111, 5'd4, 7'b0000011), 32'h1, 32'h0, 32'h0);        // f3=7
    idle(4);

    // Full queue under stall: third push is held, forwarding shows entry 2.
    stall_force = 1'b1;
    idle(1);
    send(enc_i(12'h000, 5'd0, 3'b000, 5'd6, 7'b0010011), 32'h0, 32'hA6, 32'h0);
    send(enc_i(12'h000, 5'd0, 3'b000, 5'd7, 7'b0010011), 32'h0, 32'hA7, 32'h0);
    ir = enc_i(12'h000, 5'd0, 3'b000, 5'd8, 7'b0010011); a = 32'hA8; v_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_r_out", r_out, 0);
      check("full_fwd_addr", fwd_addr, 7);
      check("full_wr_en", wr_en, 0);
    end
    @(posedge clk);
    #1;
    stall_force = 1'b0;
    send(enc_i(12'h000, 5'd0, 3'b000, 5'd8, 7'b0010011), 32'h0, 32'hA8, 32'h0);
    idle(4);

    // Reset with two entries queued: no write may escape.
    stall_force = 1'b1;
    idle(1);
    send(enc_i(12'h000, 5'd0, 3'b000, 5'd10, 7'b0010011), 32'h0, 32'hB0, 32'h0);
    send(enc_i(12'h000, 5'd0, 3'b000, 5'd11, 7'b0010011), 32'h0, 32'hB1, 32'h0);
    rst = 1'b1;
    stall_force = 1'b0;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_v_out", v_out, 0);
    check("post_rst_instret", instret, 0);
    check("post_rst_r_out", r_out, 1);
    @(posedge clk);
    #1;

    // Randomised traffic with random back-pressure and gaps.
    rand_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 7)];
      send(ri, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_en = 1'b0;
    idle(8);
    check("drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
